sram_arbiter: RTL and testbench

//  Shares one asynchronous 16-bit x 256K SRAM between two requesters: port A (UART loader) and port B (CPU/test logic).

---
 rtl/sram_arbiter.sv | 146 ++++++++++++++
 tb/tb_sram_arbiter.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - round-robin two-port arbiter and pin sequencer for an async 16-bit SRAM
module sram_arbiter #(
    parameter int SETUP_CYC = 1,
    parameter int WE_CYC    = 2,
    parameter int HOLD_CYC  = 1,
    parameter int READ_CYC  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        a_req,
    input  logic        a_we,
    input  logic [17:0] a_addr,
    input  logic [15:0] a_wdata,
    output logic        a_ack,
    output logic [15:0] a_rdata,
    input  logic        b_req,
    input  logic        b_we,
    input  logic [17:0] b_addr,
    input  logic [15:0] b_wdata,
    output logic        b_ack,
    output logic [15:0] b_rdata,
    output logic        busy,
    output logic        ram_en,
    output logic        ram_oe,
    output logic        ram_we,
    output logic [17:0] ram_addr,
    inout  wire  [15:0] ram_data
);

    typedef enum logic [2:0] {IDLE, SETUP, WPULSE, WHOLD, RWAIT, DONE} state_t;

    localparam logic [3:0] SETUP_LD = 4'(SETUP_CYC - 1);
    localparam logic [3:0] WE_LD    = 4'(WE_CYC - 1);
    localparam logic [3:0] HOLD_LD  = 4'(HOLD_CYC - 1);
    localparam logic [3:0] READ_LD  = 4'(READ_CYC - 1);

    state_t      state;
    logic [3:0]  cnt;
    logic        last_b;
    logic        sel_b;
    logic        we_q;
    logic [15:0] wdata_q;
    logic        drive;
    logic        grant_b;

    // On a tie the port that was not served last wins.
    always_comb begin
        grant_b = b_req && (!a_req || !last_b);
    end

    assign busy     = (state != IDLE);
    assign ram_data = drive ? wdata_q : 16'hzzzz;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            last_b   <= 1'b1;
            sel_b    <= 1'b0;
            we_q     <= 1'b0;
            wdata_q  <= 16'h0000;
            drive    <= 1'b0;
            ram_en   <= 1'b1;
            ram_oe   <= 1'b1;
            ram_we   <= 1'b1;
            ram_addr <= 18'd0;
            a_ack    <= 1'b0;
            b_ack    <= 1'b0;
            a_rdata  <= 16'h0000;
            b_rdata  <= 16'h0000;
        end else begin
            a_ack <= 1'b0;
            b_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (a_req || b_req) begin
                        sel_b    <= grant_b;
                        last_b   <= grant_b;
                        we_q     <= grant_b ? b_we : a_we;
                        wdata_q  <= grant_b ? b_wdata : a_wdata;
                        ram_addr <= grant_b ? b_addr : a_addr;
                        drive    <= grant_b ? b_we : a_we;
                        ram_en   <= 1'b0;
                        cnt      <= SETUP_LD;
                        state    <= SETUP;
                    end
                end
                SETUP: begin
                    if (cnt == 4'd0) begin
                        if (we_q) begin
                            ram_we <= 1'b0;
                            cnt    <= WE_LD;
                            state  <= WPULSE;
                        end else begin
                            ram_oe <= 1'b0;
                            cnt    <= READ_LD;
                            state  <= RWAIT;
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                WPULSE: begin
                    if (cnt == 4'd0) begin
                        ram_we <= 1'b1;
                        cnt    <= HOLD_LD;
                        state  <= WHOLD;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                WHOLD: begin
                    if (cnt == 4'd0) begin
                        ram_en <= 1'b1;
                        drive  <= 1'b0;
                        a_ack  <= !sel_b;
                        b_ack  <= sel_b;
                        state  <= DONE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RWAIT: begin
                    if (cnt == 4'd0) begin
                        if (sel_b) b_rdata <= ram_data;
                        else       a_rdata <= ram_data;
                        ram_oe <= 1'b1;
                        ram_en <= 1'b1;
                        a_ack  <= !sel_b;
                        b_ack  <= sel_b;
                        state  <= DONE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// tb/tb_sram_arbiter.sv - directed vector bench for sram_arbiter with a small SRAM model
module tb_sram_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_req, a_we, b_req, b_we;
    logic [17:0] a_addr, b_addr;
    logic [15:0] a_wdata, b_wdata;
    wire         a_ack, b_ack, busy, ram_en, ram_oe, ram_we;
    wire  [15:0] a_rdata, b_rdata;
    wire  [17:0] ram_addr;
    wire  [15:0] ram_data;

    int checks = 0;
    int failures = 0;

    logic [15:0] mem [0:255];

    sram_arbiter dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_ack(a_ack), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_ack(b_ack), .b_rdata(b_rdata),
        .busy(busy), .ram_en(ram_en), .ram_oe(ram_oe), .ram_we(ram_we),
        .ram_addr(ram_addr), .ram_data(ram_data)
    );

    always #5 clk = ~clk;

    // An undriven bus floats to all ones, so 16'hFFFF stands for high-Z.
    for (genvar g = 0; g < 16; g++) begin : g_pu
        pullup (ram_data[g]);
    end

    assign ram_data = (!ram_en && !ram_oe) ? mem[ram_addr[7:0]] : 16'hzzzz;

    always @(posedge ram_we) begin
        if (!ram_en) mem[ram_addr[7:0]] = ram_data;
    end

    typedef struct {
        logic        pb;
        logic        we;
        logic [17:0] addr;
        logic [15:0] wdata;
        int          lat;
        logic [15:0] rd;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic set_req(input logic pb, input logic req, input logic we,
                           input logic [17:0] addr, input logic [15:0] wd);
        if (pb) begin
            b_req = req; b_we = we; b_addr = addr; b_wdata = wd;
        end else begin
            a_req = req; a_we = we; a_addr = addr; a_wdata = wd;
        end
    endtask

    task automatic txn(input vec_t v, output int lat, output int we_lo,
                       output int oe_lo, output int bad);
        lat = -1; we_lo = 0; oe_lo = 0; bad = 0;
        @(negedge clk);
        set_req(v.pb, 1'b1, v.we, v.addr, v.wdata);
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (!ram_we) we_lo++;
            if (!ram_oe) oe_lo++;
            if (!ram_we && !ram_oe) bad++;
            if (!ram_en && ram_addr !== v.addr) bad++;
            if (v.we && !ram_en && ram_data !== v.wdata) bad++;
            if (v.pb ? a_ack : b_ack) bad++;
            if (v.pb ? b_ack : a_ack) begin
                lat = i;
                set_req(v.pb, 1'b0, 1'b0, 18'd0, 16'h0);
                break;
            end
        end
    endtask

    initial begin
        int lat, we_lo, oe_lo, bad, nack, dbl, cyc, first;
        logic [3:0] seq;
        logic [15:0] exp_a, exp_b;

        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        vecs[0] = '{1'b0, 1'b1, 18'h00010, 16'h1A2B, 5, 16'h0};
        vecs[1] = '{1'b1, 1'b0, 18'h00010, 16'h0000, 4, 16'h1A2B};
        vecs[2] = '{1'b1, 1'b1, 18'h00020, 16'hBEEF, 5, 16'h0};
        vecs[3] = '{1'b0, 1'b0, 18'h00020, 16'h0000, 4, 16'hBEEF};
        vecs[4] = '{1'b0, 1'b1, 18'h3FFFF, 16'h5A5A, 5, 16'h0};
        vecs[5] = '{1'b1, 1'b0, 18'h3FFFF, 16'h0000, 4, 16'h5A5A};

        // Reset with A already requesting.
        rst = 1'b0;
        set_req(1'b0, 1'b1, 1'b0, 18'h00005, 16'h0);
        set_req(1'b1, 1'b0, 1'b0, 18'h0, 16'h0);
        repeat (3) @(negedge clk);
        chk("rst_en", ram_en, 1);
        chk("rst_oe", ram_oe, 1);
        chk("rst_we", ram_we, 1);
        chk("rst_data_z", ram_data, 16'hFFFF);
        chk("rst_acks", {a_ack, b_ack}, 0);
        chk("rst_busy", busy, 0);
        chk("rst_addr", ram_addr, 0);
        chk("rst_rdata", {a_rdata, b_rdata}, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("first_grant", {busy, ram_en, ram_addr}, {1'b1, 1'b0, 18'h00005});
        lat = -1;
        for (int i = 2; i <= 12; i++) begin
            @(negedge clk);
            if (a_ack) begin lat = i; a_req = 1'b0; break; end
        end
        chk("first_lat", lat, 4);

        exp_a = 16'h0; exp_b = 16'h0;
        for (int k = 0; k < 6; k++) begin
            txn(vecs[k], lat, we_lo, oe_lo, bad);
            if (!vecs[k].we) begin
                if (vecs[k].pb) exp_b = vecs[k].rd;
                else            exp_a = vecs[k].rd;
            end
            chk($sformatf("v%0d_lat", k), lat, vecs[k].lat);
            chk($sformatf("v%0d_we_lo", k), we_lo, vecs[k].we ? 2 : 0);
            chk($sformatf("v%0d_oe_lo", k), oe_lo, vecs[k].we ? 0 : 2);
            chk($sformatf("v%0d_pins", k), bad, 0);
            chk($sformatf("v%0d_a_rdata", k), a_rdata, exp_a);
            chk($sformatf("v%0d_b_rdata", k), b_rdata, exp_b);
        end

        // Both ports held: alternation starting with A since B went last.
        @(negedge clk);
        set_req(1'b0, 1'b1, 1'b0, 18'h00010, 16'h0);
        set_req(1'b1, 1'b1, 1'b0, 18'h00020, 16'h0);
        nack = 0; dbl = 0; seq = 4'b0; cyc = -1;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if (a_ack && b_ack) dbl++;
            if (a_ack || b_ack) begin
                seq = {seq[2:0], b_ack};
                nack++;
                if (nack == 4) begin
                    cyc = i; a_req = 1'b0; b_req = 1'b0;
                    break;
                end
            end
        end
        chk("rr_count", nack, 4);
        chk("rr_order", seq, 4'b0101);
        chk("rr_double_ack", dbl, 0);
        chk("rr_cycles", cyc, 19);

        // Drop the request and scramble addr/wdata right after grant.
        @(negedge clk);
        set_req(1'b0, 1'b1, 1'b1, 18'h00030, 16'h1234);
        @(negedge clk);
        set_req(1'b0, 1'b0, 1'b0, 18'h00099, 16'hDEAD);
        nack = 0; first = -1; bad = 0;
        for (int i = 2; i <= 15; i++) begin
            @(negedge clk);
            if (!ram_en && (ram_addr !== 18'h00030 || ram_data !== 16'h1234)) bad++;
            if (b_ack) bad++;
            if (a_ack) begin
                nack++;
                if (first < 0) first = i;
            end
        end
        chk("drop_ack_count", nack, 1);
        chk("drop_ack_lat", first, 5);
        chk("drop_pins", bad, 0);
        chk("drop_busy", busy, 0);
        chk("drop_mem", mem[8'h30], 16'h1234);

        // Reset in the middle of the WE pulse.
        @(negedge clk);
        set_req(1'b0, 1'b1, 1'b1, 18'h00040, 16'h7777);
        repeat (3) @(negedge clk);
        chk("mid_in_wpulse", ram_we, 0);
        rst = 1'b0;
        #1;
        chk("mid_we", ram_we, 1);
        chk("mid_data_z", ram_data, 16'hFFFF);
        chk("mid_busy", busy, 0);
        chk("mid_ack", {a_ack, b_ack}, 0);
        chk("mid_rdata", {a_rdata, b_rdata}, 0);
        a_req = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        nack = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (a_ack || b_ack || busy) nack++;
        end
        chk("mid_quiet", nack, 0);

        txn('{1'b1, 1'b0, 18'h00030, 16'h0, 4, 16'h1234}, lat, we_lo, oe_lo, bad);
        chk("post_lat", lat, 4);
        chk("post_rdata", b_rdata, 16'h1234);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
